// File: rtl/serial_ripple_subtractor_if.sv
// Handshake and operand/result bundle for serial_ripple_subtractor.
//   start, a, b, bin : request and operands (master -> slave)
//   busy, done       : status; done is a one-cycle result-valid pulse
//   d, bout, ovf     : difference, borrow-out, signed overflow (slave -> master)
interface serial_ripple_subtractor_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, ovf
    );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: D = A - B - bin, one bit per clock, LSB first,
// using one full-subtractor cell and a borrow flop.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of serial_ripple_subtractor_if
//         (start/a/b/bin in, busy/done/d/bout/ovf out)
module serial_ripple_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    serial_ripple_subtractor_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ovf_q;

    logic diff;
    logic br_next;
    logic last;
    logic busy_c;
    logic done_c;

    // Full-subtractor cell on the current LSBs
    always_comb begin
        diff    = sa[0] ^ sb[0] ^ br;
        br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        last    = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            res    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        br    <= bus.bin;
                        cnt   <= '0;
                        res   <= '0;
                        // Operand MSBs are kept because SA/SB are shifted away
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_next;
                    res <= {diff, res[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        // Final bit: publish the result; diff is the result MSB
                        d_q    <= {diff, res[WIDTH-1:1]};
                        bout_q <= br_next;
                        ovf_q  <= (a_msb != b_msb) && (diff != a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
module tb_serial_ripple_subtractor;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_ripple_subtractor_if #(.WIDTH(4)) if4 ();
    serial_ripple_subtractor_if #(.WIDTH(8)) if8 ();

    serial_ripple_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    serial_ripple_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle. Returns edges from T0 to done
    // (0 if none within budget) and the number of busy cycles seen.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output int done_k, output int busy_n);
        if4.start = 1'b1;
        if4.a     = a;
        if4.b     = b;
        if4.bin   = bin;
        @(posedge clk); #1;
        if4.start = 1'b0;
        if4.a     = ~a;
        if4.b     = ~b;
        if4.bin   = ~bin;
        done_k = 0;
        busy_n = 0;
        if (if4.busy) busy_n++;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (if4.busy) busy_n++;
            if (if4.done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int done_k);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.bin   = bin;
        @(posedge clk); #1;
        if8.start = 1'b0;
        if8.a     = 8'($urandom);
        if8.b     = 8'($urandom);
        if8.bin   = 1'($urandom);
        done_k = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (if8.done) begin
                done_k = k;
                break;
            end
        end
    endtask

    initial begin
        int         done_k;
        int         busy_n;
        int         n_done;
        logic [8:0] full;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [7:0] ed;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{4'd9,  4'd3, 1'b0, 4'h6, 1'b0, 1'b1};
        vecs[1] = '{4'd3,  4'd9, 1'b0, 4'hA, 1'b1, 1'b1};
        vecs[2] = '{4'd0,  4'd0, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[3] = '{4'd8,  4'd1, 1'b0, 4'h7, 1'b0, 1'b1};
        vecs[4] = '{4'd5,  4'd5, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[5] = '{4'd7,  4'd2, 1'b1, 4'h4, 1'b0, 1'b0};
        vecs[6] = '{4'hF,  4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[7] = '{4'd7,  4'd8, 1'b0, 4'hF, 1'b1, 1'b1};
        vecs[8] = '{4'd0,  4'd1, 1'b0, 4'hF, 1'b1, 1'b0};
        vecs[9] = '{4'd4,  4'd3, 1'b1, 4'h0, 1'b0, 1'b0};

        rst = 1'b1;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_busy", 32'(if4.busy), 32'd0);
        check("reset_done", 32'(if4.done), 32'd0);
        check("reset_d",    32'(if4.d),    32'd0);
        check("reset_bout", 32'(if4.bout), 32'd0);
        check("reset_ovf",  32'(if4.ovf),  32'd0);

        for (int i = 0; i < 10; i++) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].bin, done_k, busy_n);
            check("vec_latency", 32'(done_k), 32'd4);
            check("vec_busy_cycles", 32'(busy_n), 32'd4);
            check("vec_d",    32'(if4.d),    32'(vecs[i].d));
            check("vec_bout", 32'(if4.bout), 32'(vecs[i].bout));
            check("vec_ovf",  32'(if4.ovf),  32'(vecs[i].ovf));
            @(posedge clk); #1;
            check("vec_done_pulse", 32'(if4.done), 32'd0);
            check("vec_d_hold", 32'(if4.d), 32'(vecs[i].d));
        end

        // Start re-asserted mid-RUN and held: ignored until the first IDLE edge
        if4.start = 1'b1; if4.a = 4'd12; if4.b = 4'd4; if4.bin = 1'b0;
        @(posedge clk); #1;
        if4.start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (if4.done) n_done++;
            if (k == 1) begin
                if4.start = 1'b1; if4.a = 4'd1; if4.b = 4'd2; if4.bin = 1'b0;
            end
            if (k == 4) begin
                check("held_done1", 32'(if4.done), 32'd1);
                check("held_d1",    32'(if4.d),    32'd8);
                check("held_bout1", 32'(if4.bout), 32'd0);
            end
            if (k == 5) check("held_busy_in_idle", 32'(if4.busy), 32'd0);
            if (k == 6) begin
                check("held_accept", 32'(if4.busy), 32'd1);
                if4.start = 1'b0;
            end
            if (k == 10) begin
                check("held_done2", 32'(if4.done), 32'd1);
                check("held_d2",    32'(if4.d),    32'hF);
                check("held_bout2", 32'(if4.bout), 32'd1);
                check("held_ovf2",  32'(if4.ovf),  32'd0);
            end
        end
        check("held_done_count", 32'(n_done), 32'd2);

        // Reset mid-RUN, then a fresh operation
        if4.start = 1'b1; if4.a = 4'd10; if4.b = 4'd3; if4.bin = 1'b0;
        @(posedge clk); #1;
        if4.start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (if4.done) n_done++;
            if (k == 1) rst = 1'b1;
            if (k == 2) begin
                rst = 1'b0;
                check("rst_busy", 32'(if4.busy), 32'd0);
                check("rst_d",    32'(if4.d),    32'd0);
                check("rst_bout", 32'(if4.bout), 32'd0);
                check("rst_ovf",  32'(if4.ovf),  32'd0);
            end
            if (k == 3) begin
                if4.start = 1'b1; if4.a = 4'd7; if4.b = 4'd2; if4.bin = 1'b0;
            end
            if (k == 4) if4.start = 1'b0;
            if (k == 8) begin
                check("rst_new_done", 32'(if4.done), 32'd1);
                check("rst_new_d",    32'(if4.d),    32'd5);
            end
        end
        check("rst_done_count", 32'(n_done), 32'd1);

        // WIDTH=8 random regression against a 9-bit reference subtraction
        for (int i = 0; i < 200; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            ed   = full[7:0];
            run8(ra, rb, rbin, done_k);
            check("w8_latency", 32'(done_k),   32'd8);
            check("w8_d",       32'(if8.d),    32'(ed));
            check("w8_bout",    32'(if8.bout), 32'(full[8]));
            check("w8_ovf",     32'(if8.ovf),  32'((ra[7] != rb[7]) && (ed[7] != ra[7])));
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
